// File: rtl/spr_pkg.sv
// Shared definitions for the redundancy-management blocks: per-module state encoding and default sizing.
package spr_pkg;

  localparam int N_DEF        = 6;
  localparam int THR_DEF      = 4;
  localparam int MISS_LIM_DEF = 3;

  typedef enum logic [1:0] {
    ACTIVE  = 2'd0,
    SUSPECT = 2'd1,
    PURGED  = 2'd2
  } mod_state_t;

endpackage

// File: rtl/purge_cell.sv
// Per-module health tracker: counts consecutive disagreements with the vote and purges at MISS_LIM.
// State updates one edge after the sample; no backpressure, a sample is consumed every valid cycle.
module purge_cell
  import spr_pkg::*;
#(
  parameter int MISS_LIM = MISS_LIM_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sample,
  input  logic clear,
  input  logic bit_out,
  input  logic voted,
  output logic en,
  output logic purge
);

  mod_state_t st, st_nxt;
  logic [3:0] miss, miss_nxt;
  logic [4:0] miss_inc;
  logic       mismatch;

  assign mismatch = bit_out ^ voted;
  assign miss_inc = {1'b0, miss} + 5'd1;
  assign en       = (st != PURGED);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st   <= ACTIVE;
      miss <= 4'd0;
    end else begin
      st   <= st_nxt;
      miss <= miss_nxt;
    end
  end

  always_comb begin
    st_nxt   = st;
    miss_nxt = miss;
    purge    = 1'b0;
    if (clear) begin
      st_nxt   = ACTIVE;
      miss_nxt = 4'd0;
    end else if (sample && st != PURGED) begin
      if (!mismatch) begin
        st_nxt   = ACTIVE;
        miss_nxt = 4'd0;
      end else if (miss_inc >= 5'(MISS_LIM)) begin
        // An ACTIVE module has miss=0, so MISS_LIM=1 purges straight from ACTIVE.
        st_nxt   = PURGED;
        miss_nxt = 4'd0;
        purge    = 1'b1;
      end else begin
        st_nxt   = SUSPECT;
        miss_nxt = miss_inc[3:0];
      end
    end
  end

endmodule

// File: rtl/purge_controller.sv
// Purging switch for N-modular redundancy: gates purged modules, tracks live count and sticky fail.
// Outputs update one edge after a valid sample; no backpressure, samples are frozen while fail is set.
module purge_controller
  import spr_pkg::*;
#(
  parameter int N        = N_DEF,
  parameter int THR      = THR_DEF,
  parameter int MISS_LIM = MISS_LIM_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     valid,
  input  logic [N-1:0]             mod_out,
  input  logic                     voted,
  input  logic                     clear,
  output logic [N-1:0]             mod_gated,
  output logic [N-1:0]             mod_en,
  output logic [$clog2(N+1)-1:0]   alive_cnt,
  output logic                     purge_evt,
  output logic [N-1:0]             purge_mask,
  output logic                     fail
);

  localparam int AW = $clog2(N + 1);

  logic [N-1:0]  purge_vec;
  logic [AW-1:0] alive_nxt;
  logic          sample;

  assign sample    = valid & ~fail;
  assign mod_gated = mod_out & mod_en;

  for (genvar g = 0; g < N; g++) begin : g_cell
    purge_cell #(.MISS_LIM(MISS_LIM)) u_cell (
      .clk     (clk),
      .rst_n   (rst_n),
      .sample  (sample),
      .clear   (clear),
      .bit_out (mod_out[g]),
      .voted   (voted),
      .en      (mod_en[g]),
      .purge   (purge_vec[g])
    );
  end

  // Live count now, and the count that will hold after this edge's purges land.
  always_comb begin
    alive_cnt = '0;
    alive_nxt = '0;
    for (int i = 0; i < N; i++) begin
      alive_cnt = alive_cnt + AW'(mod_en[i]);
      alive_nxt = alive_nxt + AW'(mod_en[i] & ~purge_vec[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      purge_evt  <= 1'b0;
      purge_mask <= '0;
      fail       <= 1'b0;
    end else if (clear) begin
      purge_evt  <= 1'b0;
      purge_mask <= '0;
      fail       <= 1'b0;
    end else begin
      purge_evt  <= |purge_vec;
      purge_mask <= purge_vec;
      if (int'(alive_nxt) < THR) fail <= 1'b1;
    end
  end

endmodule
